// File: rtl/segway_drive_math_pkg.sv
// Shared widths, tuning defaults and the per-side shaping helpers for the
// segway wheel-speed pipeline.
package segway_drive_math_pkg;

    localparam int SEG_W        = 32'sd12;
    localparam int SEG_SS_BITS  = 32'sd8;
    localparam int SEG_MIN_DUTY = 32'sd168;
    localparam int SEG_LOW_BAND = 32'sd42;
    localparam int SEG_GAIN_SH  = 32'sd2;
    localparam int SEG_SLEW     = 32'sd64;
    localparam int SEG_OVR_TH   = 32'sd1536;
    localparam int SEG_TF_CNT   = 32'sd4;

    localparam int TW        = SEG_W + 32'sd1;
    localparam int STEER_LO  = 32'sd1 <<< (SEG_W - 32'sd3);
    localparam int STEER_HI  = (32'sd1 <<< SEG_W) - STEER_LO;
    localparam int STEER_MID = (32'sd1 <<< (SEG_W - 32'sd1)) - 32'sd1;
    localparam int SPD_MAX   = (32'sd1 <<< (SEG_W - 32'sd1)) - 32'sd1;
    localparam int SPD_MIN   = -(32'sd1 <<< (SEG_W - 32'sd1));

    typedef logic signed [TW-1:0]    torque_t;
    typedef logic signed [SEG_W-1:0] spd_t;

    // Pot is clamped to the usable travel, centred, then scaled by 3/16.
    function automatic torque_t steer_term(input logic [SEG_W-1:0] pot, input logic en);
        logic [SEG_W-1:0] clamped;
        torque_t          c;
        torque_t          st;
        if (pot < SEG_W'(STEER_LO)) begin
            clamped = SEG_W'(STEER_LO);
        end else if (pot > SEG_W'(STEER_HI)) begin
            clamped = SEG_W'(STEER_HI);
        end else begin
            clamped = pot;
        end
        c  = $signed({1'b0, clamped}) - torque_t'(STEER_MID);
        st = (c >>> 3'd4) + (c >>> 2'd3);
        return en ? st : {TW{1'b0}};
    endfunction

    function automatic torque_t deadzone(input torque_t t);
        torque_t mag;
        torque_t res;
        mag = t[TW-1] ? -t : t;
        if (mag > torque_t'(SEG_LOW_BAND)) begin
            if (t[TW-1]) begin
                res = t - torque_t'(SEG_MIN_DUTY);
            end else begin
                res = t + torque_t'(SEG_MIN_DUTY);
            end
        end else begin
            res = t <<< SEG_GAIN_SH;
        end
        return res;
    endfunction

    function automatic spd_t sat_w(input torque_t t);
        spd_t res;
        if (t > torque_t'(SPD_MAX)) begin
            res = spd_t'(SPD_MAX);
        end else if (t < torque_t'(SPD_MIN)) begin
            res = spd_t'(SPD_MIN);
        end else begin
            res = t[SEG_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_slew_lim.sv
// Per-wheel output register: moves toward the target by at most SLEW per
// sample, or snaps to zero when the rider is powered down.
module seg_slew_lim #(
    parameter int W    = 12,
    parameter int SLEW = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         force_zero,
    input  logic [W-1:0] target,
    output logic [W-1:0] spd
);

    localparam int DW = W + 2;
    localparam logic signed [DW-1:0] SLEW_P = DW'(SLEW);
    localparam logic signed [DW-1:0] SLEW_N = DW'(-SLEW);

    logic signed [DW-1:0] diff_s;
    logic        [W-1:0]  step_s;
    logic        [W-1:0]  next_s;
    logic        [W-1:0]  spd_r;

    // Clipped step toward target; the step fits W bits so the sum wraps safely.
    always_comb begin
        diff_s = DW'($signed(target)) - DW'($signed(spd_r));
        if (diff_s > SLEW_P) begin
            step_s = W'(SLEW);
        end else if (diff_s < SLEW_N) begin
            step_s = W'(-SLEW);
        end else begin
            step_s = diff_s[W-1:0];
        end
        next_s = spd_r + step_s;
    end

    // Speed register, updated once per accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            spd_r <= {W{1'b0}};
        end else if (en) begin
            if (force_zero) begin
                spd_r <= {W{1'b0}};
            end else begin
                spd_r <= next_s;
            end
        end
    end

    assign spd = spd_r;

endmodule

// File: rtl/segway_drive_math.sv
// Three-stage wheel-speed pipeline: soft-start scaling and steering (S1),
// torque mix and deadzone shaping (S2), saturation, slew and overspeed (S3).
module segway_drive_math
    import segway_drive_math_pkg::*;
#(
    parameter int W       = SEG_W,
    parameter int SS_BITS = SEG_SS_BITS,
    parameter int SLEW    = SEG_SLEW,
    parameter int OVR_TH  = SEG_OVR_TH,
    parameter int TF_CNT  = SEG_TF_CNT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] PID_cntrl,
    input  logic [W-1:0] steer_pot,
    input  logic         en_steer,
    input  logic         pwr_up,
    output logic [W-1:0] lft_spd,
    output logic [W-1:0] rght_spd,
    output logic         spd_vld,
    output logic         too_fast
);

    localparam int PW  = W + SS_BITS + 1;
    localparam int TFW = $clog2(TF_CNT + 1);
    localparam logic [SS_BITS-1:0] SS_MAX = {SS_BITS{1'b1}};
    localparam logic [TFW-1:0]     TF_MAX = TFW'(TF_CNT);

    logic [SS_BITS-1:0]   ss_cnt_r;
    logic signed [PW-1:0] prod_s;
    torque_t              pid_ss_s;
    torque_t              st_s;
    logic                 s1_vld_r;
    torque_t              pid_ss_r;
    torque_t              st_r;
    logic                 s2_vld_r;
    torque_t              shaped_l_r;
    torque_t              shaped_r_r;
    spd_t                 tgt_l_s;
    spd_t                 tgt_r_s;
    logic                 over_s;
    logic [TFW-1:0]       tf_cnt_r;
    logic [TFW-1:0]       tf_cnt_nxt_s;
    logic                 spd_vld_r;
    logic                 too_fast_r;
    logic                 pwr_dn_s;

    // Soft-start ramp; a sample always sees the count from before its own increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_cnt_r <= {SS_BITS{1'b0}};
        end else if (!pwr_up) begin
            ss_cnt_r <= {SS_BITS{1'b0}};
        end else if (vld && (ss_cnt_r != SS_MAX)) begin
            ss_cnt_r <= ss_cnt_r + SS_BITS'(1);
        end
    end

    // S1 arithmetic: scaled PID and steering contribution.
    always_comb begin
        prod_s   = PW'($signed(PID_cntrl)) * PW'($signed({1'b0, ss_cnt_r}));
        pid_ss_s = torque_t'(prod_s >>> SS_BITS);
        st_s     = steer_term(steer_pot, en_steer);
    end

    // S1/S2 pipeline registers; data only moves with its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r   <= 1'b0;
            pid_ss_r   <= {TW{1'b0}};
            st_r       <= {TW{1'b0}};
            s2_vld_r   <= 1'b0;
            shaped_l_r <= {TW{1'b0}};
            shaped_r_r <= {TW{1'b0}};
        end else begin
            s1_vld_r <= vld;
            s2_vld_r <= s1_vld_r;
            if (vld) begin
                pid_ss_r <= pid_ss_s;
                st_r     <= st_s;
            end
            if (s1_vld_r) begin
                shaped_l_r <= deadzone(pid_ss_r + st_r);
                shaped_r_r <= deadzone(pid_ss_r - st_r);
            end
        end
    end

    // Overspeed is judged on the shaped value, before saturation and slew.
    always_comb begin
        tgt_l_s  = sat_w(shaped_l_r);
        tgt_r_s  = sat_w(shaped_r_r);
        over_s   = (shaped_l_r > torque_t'(OVR_TH)) || (shaped_r_r > torque_t'(OVR_TH));
        pwr_dn_s = !pwr_up;
        if (!over_s) begin
            tf_cnt_nxt_s = {TFW{1'b0}};
        end else if (tf_cnt_r == TF_MAX) begin
            tf_cnt_nxt_s = TF_MAX;
        end else begin
            tf_cnt_nxt_s = tf_cnt_r + TFW'(1);
        end
    end

    // S3 status registers, updated alongside the wheel speeds.
    always_ff @(posedge clk) begin
        if (rst) begin
            spd_vld_r  <= 1'b0;
            tf_cnt_r   <= {TFW{1'b0}};
            too_fast_r <= 1'b0;
        end else begin
            spd_vld_r <= s2_vld_r;
            if (s2_vld_r) begin
                tf_cnt_r   <= tf_cnt_nxt_s;
                too_fast_r <= (tf_cnt_nxt_s == TF_MAX);
            end
        end
    end

    seg_slew_lim #(.W(W), .SLEW(SLEW)) u_slew_lft (
        .clk        (clk),
        .rst        (rst),
        .en         (s2_vld_r),
        .force_zero (pwr_dn_s),
        .target     (tgt_l_s),
        .spd        (lft_spd)
    );

    seg_slew_lim #(.W(W), .SLEW(SLEW)) u_slew_rght (
        .clk        (clk),
        .rst        (rst),
        .en         (s2_vld_r),
        .force_zero (pwr_dn_s),
        .target     (tgt_r_s),
        .spd        (rght_spd)
    );

    assign spd_vld  = spd_vld_r;
    assign too_fast = too_fast_r;

endmodule

// File: tb/tb_segway_drive_math.sv
// Bench for segway_drive_math: directed scenarios plus random traffic, all
// compared against an integer-arithmetic model of the wheel-speed rules.
module tb_segway_drive_math;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [11:0] PID_cntrl;
    logic [11:0] steer_pot;
    logic        en_steer;
    logic        pwr_up;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        spd_vld;
    logic        too_fast;
    logic [25:0] obs_vec;

    always #5 clk = ~clk;

    segway_drive_math dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .PID_cntrl (PID_cntrl),
        .steer_pot (steer_pot),
        .en_steer  (en_steer),
        .pwr_up    (pwr_up),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .spd_vld   (spd_vld),
        .too_fast  (too_fast)
    );

    assign obs_vec = {spd_vld, too_fast, lft_spd, rght_spd};

    typedef struct {
        int due;
        int l;
        int r;
    } samp_t;

    samp_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    ss_m  = 0;
    int    lm    = 0;
    int    rm    = 0;
    int    tf_m  = 0;
    logic  ev_m  = 1'b0;
    logic  tfo_m = 1'b0;

    function automatic int shape(input int t);
        int a;
        a = (t < 0) ? -t : t;
        if (a > 42) return (t < 0) ? t - 168 : t + 168;
        return t * 4;
    endfunction

    function automatic int sat(input int t);
        if (t > 2047) return 2047;
        if (t < -2048) return -2048;
        return t;
    endfunction

    function automatic int slew(input int prev, input int tgt);
        int d;
        d = tgt - prev;
        if (d > 64) d = 64;
        if (d < -64) d = -64;
        return prev + d;
    endfunction

    function automatic logic [25:0] exp_vec();
        return {ev_m, tfo_m, lm[11:0], rm[11:0]};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        samp_t s;
        int    p, pss, pot, c, st;
        if (rst) begin
            q.delete();
            ss_m = 0; lm = 0; rm = 0; tf_m = 0; ev_m = 1'b0; tfo_m = 1'b0;
        end else begin
            ev_m = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                s = q.pop_front();
                ev_m = 1'b1;
                if (!pwr_up) begin
                    lm = 0; rm = 0;
                end else begin
                    lm = slew(lm, sat(s.l));
                    rm = slew(rm, sat(s.r));
                end
                if (s.l > 1536 || s.r > 1536) tf_m = (tf_m < 4) ? tf_m + 1 : 4;
                else tf_m = 0;
                tfo_m = (tf_m == 4);
            end
            if (vld) begin
                p   = int'($signed(PID_cntrl));
                pss = (p * ss_m) >>> 8;
                pot = int'(steer_pot);
                if (pot < 512) pot = 512;
                if (pot > 3584) pot = 3584;
                c   = pot - 2047;
                st  = en_steer ? (c >>> 4) + (c >>> 3) : 0;
                s.due = cyc + 2;
                s.l   = shape(pss + st);
                s.r   = shape(pss - st);
                q.push_back(s);
            end
            if (!pwr_up) ss_m = 0;
            else if (vld && ss_m < 255) ss_m = ss_m + 1;
        end
        cyc = cyc + 1;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [11:0] p,
                         input logic [11:0] sp, input logic es, input logic pu);
        rst = r; vld = v; PID_cntrl = p; steer_pot = sp; en_steer = es; pwr_up = pu;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if (obs_vec !== 26'd0) begin
                n_err++;
                $display("FAIL reset_state cyc=%0d got=%h exp=0", cyc, obs_vec);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'b1);
            n_cmp++;
            if (spd_vld !== (i == 2)) begin
                n_err++;
                $display("FAIL reset_latency i=%0d got=%0b exp=%0b", i, spd_vld, (i == 2));
            end
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_ramp();
        int ramp[7] = '{64, 128, 192, 256, 320, 384, 423};
        int e;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, 12'h000, 12'($urandom), 1'b0, 1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL ss_ramp cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 12'h100, 12'h800, 1'b0, 1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL slew_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
            if (i >= 2) begin
                e = (i - 2 < 7) ? ramp[i-2] : 423;
                n_cmp++;
                if (int'($signed(lft_spd)) !== e || int'($signed(rght_spd)) !== e || spd_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL slew_steps i=%0d got=%0d/%0d exp=%0d", i,
                             $signed(lft_spd), $signed(rght_spd), e);
                end
            end
        end
    endtask

    task automatic settle_and_check(input logic [11:0] p, input logic [11:0] sp, input logic es,
                                    input int n, input int el, input int er);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, p, sp, es, 1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL settle_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
        end
        n_cmp++;
        if (int'($signed(lft_spd)) !== el || int'($signed(rght_spd)) !== er) begin
            n_err++;
            $display("FAIL settle_value pid=%h got=%0d/%0d exp=%0d/%0d", p,
                     $signed(lft_spd), $signed(rght_spd), el, er);
        end
    endtask

    task automatic test_band_and_steer();
        settle_and_check(12'h010, 12'h800, 1'b0, 20, 60, 60);
        settle_and_check(12'hF00, 12'h800, 1'b0, 20, -423, -423);
        settle_and_check(12'h000, 12'hFFF, 1'b1, 24, 456, -456);
        settle_and_check(12'h000, 12'hFFF, 1'b0, 24, 0, 0);
    endtask

    task automatic test_overspeed();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 12'h7FF, 12'h800, 1'b0, 1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL overspeed_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
            if (i == 4 || i == 5) begin
                n_cmp++;
                if (too_fast !== (i == 5)) begin
                    n_err++;
                    $display("FAIL too_fast_rise i=%0d got=%0b exp=%0b", i, too_fast, (i == 5));
                end
            end
        end
        n_cmp++;
        if (int'($signed(lft_spd)) !== 2047 || too_fast !== 1'b1) begin
            n_err++;
            $display("FAIL overspeed_sat got=%0d tf=%0b exp=2047 tf=1", $signed(lft_spd), too_fast);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, (i == 0) ? 12'h000 : 12'h7FF, 12'h800, 1'b0, 1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL tf_clear_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
        end
        n_cmp++;
        if (too_fast !== 1'b0) begin
            n_err++;
            $display("FAIL too_fast_clear got=%0b exp=0", too_fast);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 12'h100, 12'h800, 1'b0, (i >= 4));
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL pwr_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
            if (i == 0 || i == 6 || i == 7) begin
                n_cmp++;
                if (int'($signed(lft_spd)) !== ((i == 7) ? 4 : 0) || rght_spd !== lft_spd || spd_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL pwr_drop i=%0d got=%0d/%0d exp=%0d", i, $signed(lft_spd),
                             $signed(rght_spd), (i == 7) ? 4 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), 12'($urandom),
                  12'($urandom), 1'($urandom), ($urandom_range(0, 99) < 95));
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; PID_cntrl = 12'h000; steer_pot = 12'h000;
        en_steer = 1'b0; pwr_up = 1'b0;
        test_reset();
        test_ramp();
        test_band_and_steer();
        test_overspeed();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
